// File: rtl/div_rem_seq_pkg.sv
// Shared parameters and types for the multiply-add / divide datapath.
package Verilog_parameter;

  localparam int S = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int CNT_W = $clog2(2*S) + 1;

endpackage

// File: rtl/div_rem_seq_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract.
// Purely combinational; no backpressure.
module div_step #(
  parameter int S = Verilog_parameter::S
) (
  input  logic [S:0]   rem_in,
  input  logic         bit_in,
  input  logic [S-1:0] divisor,
  output logic [S:0]   rem_out,
  output logic         q_bit
);

  logic [S:0] shifted;

  // A set top bit would be shifted out, but it already guarantees shifted >= divisor.
  assign shifted = {rem_in[S-1:0], bit_in};
  assign q_bit   = rem_in[S] | (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

// File: rtl/div_rem_seq.sv
// Sequential restoring divider recovering B and C from A*B+C; 2S cycles per divide,
// one quotient bit per clock. start is accepted only in IDLE and is otherwise dropped.
module div_rem_seq #(
  parameter int S = Verilog_parameter::S
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*S-1:0] DIVIDEND,
  input  logic [S-1:0]   DIVISOR,
  output logic           busy,
  output logic           done,
  output logic [2*S-1:0] QUOT,
  output logic [S-1:0]   REM,
  output logic           div_zero
);
  import Verilog_parameter::*;

  localparam int CW = $clog2(2*S) + 1;
  localparam logic [CW-1:0] LAST = CW'(2*S - 1);

  div_state_t     state;
  logic [2*S-1:0] dvd_q;
  logic [S-1:0]   dvs_q;
  logic [S:0]     prem;
  logic [S:0]     prem_nxt;
  logic           q_bit;
  logic [CW-1:0]  cnt;

  // Dividend bits leave at the MSB while quotient bits enter at the LSB of the same register.
  div_step #(.S(S)) u_step (
    .rem_in  (prem),
    .bit_in  (dvd_q[2*S-1]),
    .divisor (dvs_q),
    .rem_out (prem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      prem     <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      QUOT     <= '0;
      REM      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_q <= DIVIDEND;
            dvs_q <= DIVISOR;
            prem  <= '0;
            cnt   <= '0;
            if (DIVISOR == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              QUOT     <= '1;
              REM      <= '0;
              div_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_q <= {dvd_q[2*S-2:0], q_bit};
          prem  <= prem_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            QUOT     <= {dvd_q[2*S-2:0], q_bit};
            REM      <= prem_nxt[S-1:0];
            div_zero <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
